// File: rtl/ascon_word_fifo_if.sv
// Bus interface for ascon_word_fifo: write half-words, flush/pop control,
// show-ahead head entry and status flags.
// ASCON_WORD_FIFO_LEVEL_EN adds the level_o occupancy signal.
interface ascon_word_fifo_if #(
    parameter int unsigned DEPTH = 4
);
    logic        wr_en_i;
    logic [31:0] wr_data_i;
    logic        flush_i;
    logic        pop_i;
    logic [63:0] data_o;
    logic        empty_o;
    logic        full_o;
    logic        half_o;
    logic        overflow_o;
    logic        underflow_o;
`ifdef ASCON_WORD_FIFO_LEVEL_EN
    localparam int unsigned AW = $clog2(DEPTH);
    logic [AW:0] level_o;

    modport master (
        output wr_en_i, wr_data_i, flush_i, pop_i,
        input  data_o, empty_o, full_o, half_o, overflow_o, underflow_o, level_o
    );
    modport slave (
        input  wr_en_i, wr_data_i, flush_i, pop_i,
        output data_o, empty_o, full_o, half_o, overflow_o, underflow_o, level_o
    );
`else
    modport master (
        output wr_en_i, wr_data_i, flush_i, pop_i,
        input  data_o, empty_o, full_o, half_o, overflow_o, underflow_o
    );
    modport slave (
        input  wr_en_i, wr_data_i, flush_i, pop_i,
        output data_o, empty_o, full_o, half_o, overflow_o, underflow_o
    );
`endif
endinterface

// File: rtl/ascon_word_fifo.sv
// ascon_word_fifo: packs pairs of 32-bit writes into 64-bit blocks
// (first half-word in bits 63:32) and stores them in a show-ahead FIFO
// feeding the Ascon core's AD/PT FIFO ports.
// Optional ASCON_WORD_FIFO_LEVEL_EN exposes the entry count on level_o.
module ascon_word_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input logic                 clk,
    input logic                 rst_n,
    ascon_word_fifo_if.slave    bus
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [63:0]   mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [31:0]   hold_q, hold_d;
    logic          half_q, half_d;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;

    logic empty, full, complete, pop_ok, wr_ok;

    assign empty = (count_q == '0);
    assign full  = (count_q == (AW+1)'(DEPTH));

    // Next-state: packing, acceptance of completed entries and pops, sticky flags
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        hold_d   = hold_q;
        half_d   = half_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        complete = bus.wr_en_i && half_q;
        pop_ok   = bus.pop_i && !empty;
        // A pop in the same cycle frees a slot, so a full FIFO still accepts.
        wr_ok    = complete && (!full || pop_ok);

        if (bus.flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            hold_d   = '0;
            half_d   = 1'b0;
            ovf_d    = 1'b0;
            unf_d    = 1'b0;
            wr_ok    = 1'b0;
        end else begin
            if (bus.wr_en_i) begin
                half_d = !half_q;
                if (!half_q) begin
                    hold_d = bus.wr_data_i;
                end
            end
            if (complete && !wr_ok) begin
                ovf_d = 1'b1;
            end
            if (bus.pop_i && empty) begin
                unf_d = 1'b1;
            end
            if (wr_ok) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + (AW+1)'(wr_ok) - (AW+1)'(pop_ok);
        end
    end

    // State register and entry storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            hold_q   <= '0;
            half_q   <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            hold_q   <= hold_d;
            half_q   <= half_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            if (wr_ok) begin
                mem_q[wr_ptr_q] <= {hold_q, bus.wr_data_i};
            end
        end
    end

    assign bus.data_o      = mem_q[rd_ptr_q];
    assign bus.empty_o     = empty;
    assign bus.full_o      = full;
    assign bus.half_o      = half_q;
    assign bus.overflow_o  = ovf_q;
    assign bus.underflow_o = unf_q;
`ifdef ASCON_WORD_FIFO_LEVEL_EN
    assign bus.level_o     = count_q;
`endif

endmodule

// File: tb/tb_ascon_word_fifo.sv
// Scoreboard bench for ascon_word_fifo: a queue-based reference model
// predicts outputs after each clock; a monitor compares after each edge.
module tb_ascon_word_fifo;
    localparam int unsigned DEPTH = 4;

    typedef struct {
        logic [63:0] data;
        logic        has_data;
        logic        empty;
        logic        full;
        logic        half;
        logic        ovf;
        logic        unf;
        int          level;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_mis;

    ascon_word_fifo_if #(.DEPTH(DEPTH)) bus ();
    ascon_word_fifo #(.DEPTH(DEPTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    // reference model state
    logic [63:0] m_q [$];
    logic [31:0] m_hold;
    logic        m_half;
    logic        m_ovf;
    logic        m_unf;
    exp_t        exp_q [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_mis++;
            $display("FAIL %s: got %h required %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_hold = '0;
        m_half = 1'b0;
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
    endtask

    task automatic model_step(input logic wr, input logic [31:0] d, input logic fl, input logic pop);
        bit was_full;
        bit pop_ok;
        if (fl) begin
            model_reset();
        end else begin
            was_full = (m_q.size() == DEPTH);
            pop_ok   = pop && (m_q.size() != 0);
            if (pop && m_q.size() == 0) m_unf = 1'b1;
            if (pop_ok) void'(m_q.pop_front());
            if (wr) begin
                if (!m_half) begin
                    m_hold = d;
                    m_half = 1'b1;
                end else begin
                    m_half = 1'b0;
                    if (!was_full || pop_ok) m_q.push_back({m_hold, d});
                    else m_ovf = 1'b1;
                end
            end
        end
    endtask

    function automatic exp_t snapshot();
        exp_t e;
        e.has_data = (m_q.size() != 0);
        e.data     = e.has_data ? m_q[0] : 64'h0;
        e.empty    = (m_q.size() == 0);
        e.full     = (m_q.size() == DEPTH);
        e.half     = m_half;
        e.ovf      = m_ovf;
        e.unf      = m_unf;
        e.level    = m_q.size();
        return e;
    endfunction

    // one clock of stimulus; expected post-edge state goes to the scoreboard
    task automatic cyc(input logic wr, input logic [31:0] d, input logic fl, input logic pop);
        @(negedge clk);
        bus.wr_en_i   = wr;
        bus.wr_data_i = d;
        bus.flush_i   = fl;
        bus.pop_i     = pop;
        model_step(wr, d, fl, pop);
        exp_q.push_back(snapshot());
    endtask

    task automatic idle();
        cyc(1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_data"},  bus.data_o, 64'h0);
        chk({tag, "_empty"}, 64'(bus.empty_o), 64'd1);
        chk({tag, "_full"},  64'(bus.full_o), 64'd0);
        chk({tag, "_half"},  64'(bus.half_o), 64'd0);
        chk({tag, "_ovf"},   64'(bus.overflow_o), 64'd0);
        chk({tag, "_unf"},   64'(bus.underflow_o), 64'd0);
`ifdef ASCON_WORD_FIFO_LEVEL_EN
        chk({tag, "_level"}, 64'(bus.level_o), 64'd0);
`endif
    endtask

    // monitor: after each active edge, compare DUT outputs with the next expectation
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("empty", 64'(bus.empty_o), 64'(e.empty));
                chk("full",  64'(bus.full_o), 64'(e.full));
                chk("half",  64'(bus.half_o), 64'(e.half));
                chk("overflow",  64'(bus.overflow_o), 64'(e.ovf));
                chk("underflow", 64'(bus.underflow_o), 64'(e.unf));
                if (e.has_data) chk("data", bus.data_o, e.data);
`ifdef ASCON_WORD_FIFO_LEVEL_EN
                chk("level", 64'(bus.level_o), 64'(e.level));
`endif
            end
        end
    end

    // watchdog
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running required finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] w;
        n_cmp = 0;
        n_mis = 0;
        bus.wr_en_i   = 1'b0;
        bus.wr_data_i = '0;
        bus.flush_i   = 1'b0;
        bus.pop_i     = 1'b0;
        model_reset();
        rst_n = 1'b0;
        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        idle();

        // basic packing
        cyc(1'b1, 32'h01234567, 1'b0, 1'b0);
        cyc(1'b1, 32'h89ABCDEF, 1'b0, 1'b0);
        @(posedge clk);
        #2;
        chk("first_block", bus.data_o, 64'h0123456789ABCDEF);
        cyc(1'b0, 32'h0, 1'b0, 1'b1);

        // fill, then overflow with two more halves, then drain in order
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 32'hA000_0000 + 32'(i), 1'b0, 1'b0);
            cyc(1'b1, 32'hB000_0000 + 32'(i), 1'b0, 1'b0);
        end
        cyc(1'b1, 32'hDEAD_0001, 1'b0, 1'b0);
        cyc(1'b1, 32'hDEAD_0002, 1'b0, 1'b0);
        @(posedge clk);
        #2;
        chk("overflow_set", 64'(bus.overflow_o), 64'd1);
        for (int i = 0; i < 4; i++) cyc(1'b0, 32'h0, 1'b0, 1'b1);

        // full FIFO: completing write with pop is accepted
        cyc(1'b0, 32'h0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 32'hC000_0000 + 32'(i), 1'b0, 1'b0);
            cyc(1'b1, 32'hD000_0000 + 32'(i), 1'b0, 1'b0);
        end
        cyc(1'b1, 32'h1111_1111, 1'b0, 1'b0);
        cyc(1'b1, 32'h2222_2222, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) cyc(1'b0, 32'h0, 1'b0, 1'b1);

        // underflow, then write+pop while empty, then flush clears flag
        cyc(1'b0, 32'h0, 1'b0, 1'b1);
        cyc(1'b1, 32'h3333_3333, 1'b0, 1'b0);
        cyc(1'b1, 32'h4444_4444, 1'b0, 1'b1);
        cyc(1'b0, 32'h0, 1'b1, 1'b0);

        // half held plus two entries, flush with write asserted
        for (int i = 0; i < 5; i++) cyc(1'b1, 32'h5500_0000 + 32'(i), 1'b0, 1'b0);
        cyc(1'b1, 32'h6666_6666, 1'b1, 1'b0);
        idle();

        // pointer wrap: ten write/pop pairs
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, 32'h7000_0000 + 32'(i), 1'b0, 1'b0);
            cyc(1'b1, 32'h8000_0000 + 32'(i), 1'b0, 1'b0);
            cyc(1'b0, 32'h0, 1'b0, 1'b1);
        end

        // randomized traffic
        for (int i = 0; i < 500; i++) begin
            w = $urandom;
            cyc(($urandom_range(0, 9) < 6), w, ($urandom_range(0, 49) == 0),
                ($urandom_range(0, 9) < 4));
        end

        // asynchronous reset mid-fill
        cyc(1'b1, 32'h9999_0000, 1'b0, 1'b0);
        cyc(1'b1, 32'h9999_0001, 1'b0, 1'b0);
        cyc(1'b1, 32'h9999_0002, 1'b0, 1'b0);
        @(negedge clk);
        bus.wr_en_i = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        idle();
        idle();

        @(posedge clk);
        #3;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
